// File: rtl/chord_sequencer.sv
// chord_sequencer: walks the song ROM, groups consecutive words into chords of
// up to MAX_NOTES notes, strobes each note into the chord player, then holds
// activate for the chord's longest duration (counted in beats) before moving
// on to the next chord.
//
// Player handshake: load_new_note is a one-cycle strobe with no back-pressure.
// note_to_load, duration and weight are stable in the strobe cycle and stay
// held until the next word is latched. activate is a level: high exactly
// while the chord plays, and never high in the same cycle as a load strobe.
module chord_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_NOTES  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  song_start,
  input  logic                  beat,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic [5:0]            note_to_load,
  output logic [5:0]            duration,
  output logic [1:0]            weight,
  output logic                  load_new_note,
  output logic                  activate,
  output logic                  song_done,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = $clog2(MAX_NOTES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    LOAD  = 3'd3,
    PLAY  = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] note_cnt;
  logic [5:0]       max_dur;
  logic [5:0]       beat_cnt;
  logic             more_q;
  logic             load_q;

  // ROM word fields
  logic [5:0] rom_note;
  logic [5:0] rom_dur;
  logic       rom_more;
  logic       rom_end;
  logic [1:0] rom_wt;

  assign rom_note = rom_data[5:0];
  assign rom_dur  = rom_data[11:6];
  assign rom_more = rom_data[12];
  assign rom_end  = rom_data[13];
  assign rom_wt   = rom_data[15:14];

  logic [CNT_W-1:0] cnt_inc;
  logic [5:0]       beat_inc;

  assign cnt_inc  = note_cnt + CNT_W'(1);
  assign beat_inc = beat_cnt + 6'd1;

  // The strobe register stays set while paused in LOAD, so the pulse is
  // gated here and fires once play resumes.
  assign load_new_note = load_q & play_enable;
  assign state_dbg     = state;

  // Sequencer FSM with registered outputs; everything freezes while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rom_addr     <= '0;
      note_to_load <= '0;
      duration     <= '0;
      weight       <= '0;
      load_q       <= 1'b0;
      activate     <= 1'b0;
      song_done    <= 1'b0;
      note_cnt     <= '0;
      max_dur      <= '0;
      beat_cnt     <= '0;
      more_q       <= 1'b0;
    end else if (play_enable) begin
      case (state)
        IDLE: begin
          if (song_start) begin
            song_done <= 1'b0;
            rom_addr  <= '0;
            note_cnt  <= '0;
            max_dur   <= '0;
            beat_cnt  <= '0;
            state     <= FETCH;
          end
        end

        // Address has been presented; the ROM word arrives next cycle.
        FETCH: begin
          state <= LATCH;
        end

        LATCH: begin
          note_to_load <= rom_note;
          duration     <= rom_dur;
          weight       <= rom_wt;
          more_q       <= rom_more;
          if (rom_end) begin
            if (note_cnt == '0) begin
              song_done <= 1'b1;
              state     <= DONE;
            end else begin
              // Flush the partial chord; the end word is fetched again after GAP.
              activate <= 1'b1;
              state    <= PLAY;
            end
          end else begin
            load_q <= 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          load_q   <= 1'b0;
          note_cnt <= cnt_inc;
          rom_addr <= rom_addr + ADDR_WIDTH'(1);
          if (duration > max_dur) begin
            max_dur <= duration;
          end
          // A continuation flag on the last voice is dropped: the chord is full.
          if (more_q && (cnt_inc < CNT_W'(MAX_NOTES))) begin
            state <= FETCH;
          end else begin
            activate <= 1'b1;
            state    <= PLAY;
          end
        end

        PLAY: begin
          if (max_dur == 6'd0) begin
            activate <= 1'b0;
            state    <= GAP;
          end else if (beat) begin
            beat_cnt <= beat_inc;
            if (beat_inc >= max_dur) begin
              activate <= 1'b0;
              state    <= GAP;
            end
          end
        end

        GAP: begin
          note_cnt <= '0;
          max_dur  <= '0;
          beat_cnt <= '0;
          state    <= FETCH;
        end

        DONE: begin
          if (song_start) begin
            song_done <= 1'b0;
            rom_addr  <= '0;
            note_cnt  <= '0;
            max_dur   <= '0;
            beat_cnt  <= '0;
            state     <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chord_sequencer.sv
// Bench for chord_sequencer: synchronous song ROM model, free-running beat
// source, load/chord scoreboard driven from expected-value tables, and
// hand-written sequences for pause, zero-duration chords and mid-load reset.
module tb_chord_sequencer;

  localparam int AW = 7;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd4;
  localparam logic [2:0] S_DONE = 3'd6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play_enable = 1'b0;
  logic          song_start = 1'b0;
  logic          beat = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic [5:0]    note_to_load;
  logic [5:0]    duration;
  logic [1:0]    weight;
  logic          load_new_note;
  logic          activate;
  logic          song_done;
  logic [2:0]    state_dbg;

  chord_sequencer #(.ADDR_WIDTH(AW), .MAX_NOTES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_enable  (play_enable),
    .song_start   (song_start),
    .beat         (beat),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note_to_load (note_to_load),
    .duration     (duration),
    .weight       (weight),
    .load_new_note(load_new_note),
    .activate     (activate),
    .song_done    (song_done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM and beat models ----------------
  logic [15:0] rom [0:(1<<AW)-1];

  always @(posedge clk) rom_data <= rom[rom_addr];

  logic beat_en = 1'b1;
  int   bdiv = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bdiv = (bdiv == 3) ? 0 : bdiv + 1;
      beat = beat_en && (bdiv == 0);
    end
  end

  function automatic logic [15:0] mkw(input int note, input int dur, input bit more,
                                      input bit last, input int wt);
    logic [5:0] n6;
    logic [5:0] d6;
    logic [1:0] w2;
    n6 = note[5:0];
    d6 = dur[5:0];
    w2 = wt[1:0];
    return {w2, last, more, d6, n6};
  endfunction

  localparam logic [15:0] END_W = 16'h2000;

  // ---------------- expected tables ----------------
  typedef struct {
    int         scen;
    logic [5:0] note;
    logic [5:0] dur;
    logic [1:0] wt;
  } load_vec_t;

  typedef struct {
    int         scen;
    logic [5:0] beats;
  } chord_vec_t;

  load_vec_t  lv [14];
  chord_vec_t cv [6];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [13:0] exp_q[$];
  logic [5:0]  exp_beats_q[$];
  int          load_cyc_q[$];
  int          cyc = 0;
  int          act_cyc = 0;
  int          act_beats = 0;
  int          last_act_cyc = 0;
  logic        prev_act = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int s);
    for (int i = 0; i < 14; i++)
      if (lv[i].scen == s) exp_q.push_back({lv[i].wt, lv[i].dur, lv[i].note});
    for (int i = 0; i < 6; i++)
      if (cv[i].scen == s) exp_beats_q.push_back(cv[i].beats);
  endtask

  // Monitor: loads, chord lengths in beats, load/activate exclusivity.
  always @(negedge clk) begin
    logic [13:0] e;
    logic [5:0]  eb;
    if (reset) begin
      checks++;
      if (load_new_note && activate) begin
        failures++;
        $display("FAIL load_activate_overlap got=1 expected=0 cycle=%0d", cyc);
      end
      if (load_new_note) begin
        load_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL load_unexpected got note=%0d dur=%0d w=%0d expected=none",
                   note_to_load, duration, weight);
        end else begin
          e = exp_q.pop_front();
          if ({weight, duration, note_to_load} !== e) begin
            failures++;
            $display("FAIL load_word got note=%0d dur=%0d w=%0d expected note=%0d dur=%0d w=%0d",
                     note_to_load, duration, weight, e[5:0], e[11:6], e[13:12]);
          end
        end
      end
      if (activate) begin
        act_cyc++;
        if (beat && play_enable) act_beats++;
      end
      if (prev_act && !activate) begin
        last_act_cyc = act_cyc;
        checks++;
        if (exp_beats_q.size() == 0) begin
          failures++;
          $display("FAIL chord_unexpected got beats=%0d expected=none", act_beats);
        end else begin
          eb = exp_beats_q.pop_front();
          if (act_beats != int'(eb)) begin
            failures++;
            $display("FAIL chord_beats got=%0d expected=%0d", act_beats, eb);
          end
        end
        act_cyc = 0;
        act_beats = 0;
      end
      prev_act = activate;
    end else begin
      prev_act = 1'b0;
      act_cyc = 0;
      act_beats = 0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << AW); i++) rom[i] = END_W;
  endtask

  task automatic start_song();
    @(posedge clk); #1;
    song_start = 1'b1;
    @(posedge clk); #1;
    song_start = 1'b0;
    @(negedge clk);
    chk("start_clears", {24'd0, song_done, rom_addr}, 32'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!song_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, song_done}, 32'd1);
    chk({name, "_done_state"}, {28'd0, activate, state_dbg}, {28'd0, 1'b0, S_DONE});
    chk({name, "_loads_left"}, exp_q.size(), 32'd0);
    chk({name, "_chords_left"}, exp_beats_q.size(), 32'd0);
  endtask

  task automatic wait_act(input int budget);
    int n;
    n = 0;
    while (!activate && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_activate", {31'd0, activate}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    lv[0]  = '{0, 6'd36, 6'd4,  2'd1};
    lv[1]  = '{0, 6'd32, 6'd4,  2'd2};
    lv[2]  = '{0, 6'd26, 6'd4,  2'd3};
    lv[3]  = '{1, 6'd20, 6'd20, 2'd0};
    lv[4]  = '{1, 6'd26, 6'd8,  2'd1};
    lv[5]  = '{1, 6'd30, 6'd4,  2'd2};
    lv[6]  = '{2, 6'd1,  6'd2,  2'd0};
    lv[7]  = '{2, 6'd2,  6'd3,  2'd1};
    lv[8]  = '{2, 6'd3,  6'd5,  2'd2};
    lv[9]  = '{2, 6'd4,  6'd6,  2'd3};
    lv[10] = '{3, 6'd44, 6'd6,  2'd1};
    lv[11] = '{4, 6'd10, 6'd0,  2'd2};
    lv[12] = '{5, 6'd5,  6'd3,  2'd0};
    lv[13] = '{5, 6'd6,  6'd3,  2'd0};
    cv[0]  = '{0, 6'd4};
    cv[1]  = '{1, 6'd20};
    cv[2]  = '{2, 6'd5};
    cv[3]  = '{2, 6'd6};
    cv[4]  = '{3, 6'd6};
    cv[5]  = '{4, 6'd0};

    clear_rom();
    reset = 1'b0;
    play_enable = 1'b1;
    tick(3);
    @(negedge clk);
    chk("reset_outputs", {8'd0, rom_addr, note_to_load, duration, weight,
                          load_new_note, activate, song_done}, 32'd0);
    chk("reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    @(posedge clk); #1;
    reset = 1'b1;
    tick(5);
    @(negedge clk);
    chk("idle_waits", {29'd0, state_dbg}, {29'd0, S_IDLE});

    // Scenario 0: three-note chord, 4 beats, then end.
    clear_rom();
    rom[0] = mkw(36, 4, 1, 0, 1);
    rom[1] = mkw(32, 4, 1, 0, 2);
    rom[2] = mkw(26, 4, 0, 0, 3);
    load_cyc_q.delete();
    push_exp(0);
    start_song();
    wait_done("s0", 300);
    chk("s0_load_count", load_cyc_q.size(), 32'd3);
    if (load_cyc_q.size() == 3) begin
      chk("s0_load_gap1", load_cyc_q[1] - load_cyc_q[0], 32'd3);
      chk("s0_load_gap2", load_cyc_q[2] - load_cyc_q[1], 32'd3);
    end
    tick(6);
    @(negedge clk);
    chk("s0_done_held", {29'd0, song_done, state_dbg[1:0]}, {29'd0, 1'b1, S_DONE[1:0]});

    // Scenario 1: longest duration wins; pause mid-play; stray song_start.
    clear_rom();
    rom[0] = mkw(20, 20, 1, 0, 0);
    rom[1] = mkw(26, 8, 1, 0, 1);
    rom[2] = mkw(30, 4, 0, 0, 2);
    push_exp(1);
    start_song();
    wait_act(200);
    tick(2);
    song_start = 1'b1;
    tick(1);
    song_start = 1'b0;
    tick(20);
    play_enable = 1'b0;
    tick(50);
    @(negedge clk);
    chk("pause_hold_a", {28'd0, activate, state_dbg}, {28'd0, 1'b1, S_PLAY});
    tick(50);
    @(negedge clk);
    chk("pause_hold_b", {28'd0, activate, state_dbg}, {28'd0, 1'b1, S_PLAY});
    @(posedge clk); #1;
    play_enable = 1'b1;
    wait_done("s1", 600);

    // Scenario 2: four continued words -> 3-note chord, then a lone note.
    clear_rom();
    rom[0] = mkw(1, 2, 1, 0, 0);
    rom[1] = mkw(2, 3, 1, 0, 1);
    rom[2] = mkw(3, 5, 1, 0, 2);
    rom[3] = mkw(4, 6, 1, 0, 3);
    push_exp(2);
    start_song();
    wait_done("s2", 400);

    // Scenario 3: single note, end word carrying a zero duration.
    clear_rom();
    rom[0] = mkw(44, 6, 0, 0, 1);
    rom[1] = mkw(0, 0, 0, 1, 0);
    push_exp(3);
    start_song();
    wait_done("s3", 300);

    // Scenario 4: zero-duration chord plays for one cycle.
    clear_rom();
    beat_en = 1'b0;
    rom[0] = mkw(10, 0, 0, 0, 2);
    push_exp(4);
    start_song();
    wait_done("s4", 100);
    chk("s4_act_cycles", last_act_cyc, 32'd1);
    beat_en = 1'b1;

    // Scenario 5: reset while the second note is being loaded.
    clear_rom();
    rom[0] = mkw(5, 3, 1, 0, 0);
    rom[1] = mkw(6, 3, 1, 0, 0);
    rom[2] = mkw(7, 3, 0, 0, 0);
    push_exp(5);
    start_song();
    n = 0;
    @(negedge clk);
    while (!(load_new_note && note_to_load == 6'd6) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s5_saw_load2", {31'd0, load_new_note}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("s5_reset_outputs", {8'd0, rom_addr, note_to_load, duration, weight,
                             load_new_note, activate, song_done}, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(10);
    @(negedge clk);
    chk("s5_idle_after", {21'd0, state_dbg, rom_addr, activate},
        {21'd0, S_IDLE, 7'd0, 1'b0});
    chk("s5_loads_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
